// File: rtl/vcve2_vrf_seq_pkg.sv
// Shared types for the vector register-file sequencer: state codes, SEW/LMUL
// encodings, pending-operand tags and LMUL group helpers.
package vcve2_vrf_seq_pkg;

  typedef logic [2:0] vrf_state_t;
  localparam vrf_state_t VRF_IDLE  = 3'd0;
  localparam vrf_state_t VRF_READ1 = 3'd1;
  localparam vrf_state_t VRF_READ2 = 3'd2;
  localparam vrf_state_t VRF_READ3 = 3'd3;
  localparam vrf_state_t V_OP      = 3'd4;
  localparam vrf_state_t VRF_WRITE = 3'd5;

  typedef enum logic [2:0] {
    VSEW_8  = 3'b000,
    VSEW_16 = 3'b001,
    VSEW_32 = 3'b010,
    VSEW_64 = 3'b011
  } vsew_e;

  typedef enum logic [2:0] {
    VLMUL_1    = 3'b000,
    VLMUL_2    = 3'b001,
    VLMUL_4    = 3'b010,
    VLMUL_8    = 3'b011,
    VLMUL_RSVD = 3'b100,
    VLMUL_F8   = 3'b101,
    VLMUL_F4   = 3'b110,
    VLMUL_F2   = 3'b111
  } vlmul_e;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_A    = 2'd1,
    PEND_B    = 2'd2,
    PEND_C    = 2'd3
  } vrf_pend_e;

  // Fractional LMULs still occupy one whole register.
  function automatic logic [3:0] vlmul_group_size(vlmul_e vlmul);
    case (vlmul)
      VLMUL_2: return 4'd2;
      VLMUL_4: return 4'd4;
      VLMUL_8: return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic vreg_aligned(logic [4:0] vreg, vlmul_e vlmul);
    return (vreg & (5'(vlmul_group_size(vlmul)) - 5'd1)) == 5'd0;
  endfunction

endpackage

// File: rtl/vcve2_vrf_seq_if.sv
// Decoder start handshake, single VRF port and VALU operand bus of the sequencer.
interface vcve2_vrf_seq_if #(
  parameter int VLEN = 128
);
  import vcve2_vrf_seq_pkg::*;

  logic            start_valid_i;
  logic            start_ready_o;
  logic [4:0]      vs1_i;
  logic [4:0]      vs2_i;
  logic [4:0]      vd_i;
  logic [1:0]      nsrc_i;
  vlmul_e          vlmul_i;
  vsew_e           vsew_i;

  logic            vrf_req_o;
  logic            vrf_we_o;
  logic [4:0]      vrf_addr_o;
  logic [VLEN-1:0] vrf_wdata_o;
  logic [VLEN-1:0] vrf_rdata_i;

  logic [VLEN-1:0] op_a_o;
  logic [VLEN-1:0] op_b_o;
  logic [VLEN-1:0] op_c_o;
  logic            valu_valid_o;
  logic            valu_ready_i;
  logic [VLEN-1:0] valu_result_i;

  modport master (
    input  start_valid_i, vs1_i, vs2_i, vd_i, nsrc_i, vlmul_i, vsew_i,
    output start_ready_o,
    output vrf_req_o, vrf_we_o, vrf_addr_o, vrf_wdata_o,
    input  vrf_rdata_i,
    output op_a_o, op_b_o, op_c_o, valu_valid_o,
    input  valu_ready_i, valu_result_i
  );

  modport slave (
    output start_valid_i, vs1_i, vs2_i, vd_i, nsrc_i, vlmul_i, vsew_i,
    input  start_ready_o,
    input  vrf_req_o, vrf_we_o, vrf_addr_o, vrf_wdata_o,
    output vrf_rdata_i,
    input  op_a_o, op_b_o, op_c_o, valu_valid_o,
    output valu_ready_i, valu_result_i
  );

endinterface

// File: rtl/vcve2_vrf_seq.sv
// Sequences one vector instruction over the LMUL group: read up to three
// sources per register, hand them to the VALU, write the result back.
module vcve2_vrf_seq
  import vcve2_vrf_seq_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_i,
  vcve2_vrf_seq_if.master bus,
  output logic            done_o,
  output logic            illegal_o,
  output vrf_state_t      state_o
);

  vrf_state_t      r_state;
  vrf_state_t      w_next;
  vrf_pend_e       r_pend;
  vrf_pend_e       w_pendNext;
  logic [2:0]      r_idx;
  logic [3:0]      r_gsize;
  logic [1:0]      r_nsrc;
  logic [4:0]      r_vs1;
  logic [4:0]      r_vs2;
  logic [4:0]      r_vd;
  logic [VLEN-1:0] r_opA;
  logic [VLEN-1:0] r_opB;
  logic [VLEN-1:0] r_opC;
  logic [VLEN-1:0] r_result;
  logic            r_illegal;

  logic            w_idle;
  logic            w_accept;
  logic            w_illegal;
  logic            w_legalAccept;
  logic            w_kill;
  logic            w_lastIdx;
  logic            w_valuFire;
  logic [4:0]      w_idx;
  logic            w_req;
  logic            w_we;
  logic [4:0]      w_addr;
  logic            w_valid;
  logic            w_done;

  assign w_idle        = (r_state == VRF_IDLE);
  assign w_accept      = bus.start_valid_i && w_idle;
  assign w_illegal     = !(bus.vsew_i inside {VSEW_8, VSEW_16, VSEW_32})
                       || (bus.vlmul_i == VLMUL_RSVD)
                       || !vreg_aligned(bus.vd_i, bus.vlmul_i)
                       || ((bus.nsrc_i != 2'd0) && !vreg_aligned(bus.vs2_i, bus.vlmul_i))
                       || ((bus.nsrc_i >= 2'd2) && !vreg_aligned(bus.vs1_i, bus.vlmul_i));
  assign w_legalAccept = w_accept && !w_illegal;
  assign w_kill        = kill_i && !w_idle;
  assign w_idx         = {2'b00, r_idx};
  assign w_lastIdx     = ({1'b0, r_idx} == (r_gsize - 4'd1));
  assign w_valuFire    = w_valid && bus.valu_ready_i;

  // Each READk issues one request; its data lands in the following state, tagged by pend.
  always_comb begin
    w_next     = r_state;
    w_pendNext = PEND_NONE;
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_addr     = 5'd0;
    w_valid    = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      VRF_IDLE: begin
        if (w_legalAccept) w_next = (bus.nsrc_i != 2'd0) ? VRF_READ1 : V_OP;
      end
      VRF_READ1: begin
        w_req      = 1'b1;
        w_addr     = r_vs2 + w_idx;
        w_pendNext = PEND_A;
        w_next     = (r_nsrc >= 2'd2) ? VRF_READ2 : V_OP;
      end
      VRF_READ2: begin
        w_req      = 1'b1;
        w_addr     = r_vs1 + w_idx;
        w_pendNext = PEND_B;
        w_next     = (r_nsrc == 2'd3) ? VRF_READ3 : V_OP;
      end
      VRF_READ3: begin
        w_req      = 1'b1;
        w_addr     = r_vd + w_idx;
        w_pendNext = PEND_C;
        w_next     = V_OP;
      end
      V_OP: begin
        if (r_pend == PEND_NONE) begin
          w_valid = 1'b1;
          if (bus.valu_ready_i) w_next = VRF_WRITE;
        end
      end
      VRF_WRITE: begin
        w_req  = 1'b1;
        w_we   = 1'b1;
        w_addr = r_vd + w_idx;
        w_done = w_lastIdx;
        if (w_lastIdx) w_next = VRF_IDLE;
        else           w_next = (r_nsrc != 2'd0) ? VRF_READ1 : V_OP;
      end
      default: w_next = VRF_IDLE;
    endcase
    if (w_kill) begin
      w_next     = VRF_IDLE;
      w_pendNext = PEND_NONE;
      w_req      = 1'b0;
      w_we       = 1'b0;
      w_valid    = 1'b0;
      w_done     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= VRF_IDLE;
      r_pend    <= PEND_NONE;
      r_idx     <= 3'd0;
      r_gsize   <= 4'd0;
      r_nsrc    <= 2'd0;
      r_vs1     <= 5'd0;
      r_vs2     <= 5'd0;
      r_vd      <= 5'd0;
      r_opA     <= '0;
      r_opB     <= '0;
      r_opC     <= '0;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pend    <= w_pendNext;
      r_illegal <= w_accept && w_illegal;
      if (w_legalAccept) begin
        r_vs1   <= bus.vs1_i;
        r_vs2   <= bus.vs2_i;
        r_vd    <= bus.vd_i;
        r_nsrc  <= bus.nsrc_i;
        r_gsize <= vlmul_group_size(bus.vlmul_i);
        r_idx   <= 3'd0;
      end else if ((r_state == VRF_WRITE) && !w_lastIdx && !w_kill) begin
        r_idx <= r_idx + 3'd1;
      end
      if (!w_kill) begin
        case (r_pend)
          PEND_A:  r_opA <= bus.vrf_rdata_i;
          PEND_B:  r_opB <= bus.vrf_rdata_i;
          PEND_C:  r_opC <= bus.vrf_rdata_i;
          default: ;
        endcase
      end
      if (w_valuFire) r_result <= bus.valu_result_i;
    end
  end

  assign bus.start_ready_o = w_idle;
  assign bus.vrf_req_o     = w_req;
  assign bus.vrf_we_o      = w_we;
  assign bus.vrf_addr_o    = w_addr;
  assign bus.vrf_wdata_o   = r_result;
  assign bus.op_a_o        = r_opA;
  assign bus.op_b_o        = r_opB;
  assign bus.op_c_o        = r_opC;
  assign bus.valu_valid_o  = w_valid;
  assign done_o            = w_done;
  assign illegal_o         = r_illegal;
  assign state_o           = r_state;

endmodule

// File: tb/tb_vcve2_vrf_seq.sv
// Bench for vcve2_vrf_seq: VRF and VALU models plus a transaction-level reference
// of the expected VRF access stream and operand triples.
module tb_vcve2_vrf_seq;
  import vcve2_vrf_seq_pkg::*;

  localparam int VLEN = 128;
  typedef logic [VLEN-1:0] vec_t;
  typedef struct { logic we; logic [4:0] addr; vec_t data; logic last; } acc_t;
  typedef struct { vec_t a; vec_t b; vec_t c; } ops_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kill = 1'b0;
  logic       doneO;
  logic       illegalO;
  vrf_state_t stateO;

  vcve2_vrf_seq_if #(.VLEN(VLEN)) bus();

  vcve2_vrf_seq #(.VLEN(VLEN)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .kill_i   (kill),
    .bus      (bus),
    .done_o   (doneO),
    .illegal_o(illegalO),
    .state_o  (stateO)
  );

  always #5 clk = ~clk;

  vec_t       envMem[32];
  vec_t       refMem[32];
  acc_t       accQ[$];
  ops_t       opQ[$];
  ops_t       kept;
  ops_t       curOps;
  acc_t       curAcc;
  int         reqLog[$];
  int         doneSeen = 0;
  int         validCycles = 0;
  int         readyDelay = 0;
  int         validCnt = 0;
  logic [1:0] curNsrc = 2'd0;
  int         nChecks = 0;
  int         nPass = 0;

  function automatic vec_t aluFn(vec_t a, vec_t b, vec_t c, logic [1:0] n);
    case (n)
      2'd0:    return 128'hCAFE;
      2'd1:    return a ^ {VLEN/4{4'h5}};
      2'd2:    return a + b;
      default: return (a + b) ^ c;
    endcase
  endfunction

  function automatic int modelG(logic [2:0] lm);
    case (lm)
      3'd1:    return 2;
      3'd2:    return 4;
      3'd3:    return 8;
      3'd4:    return 0;
      default: return 1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input vec_t act, input vec_t exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // VRF with one-cycle read latency, and an ALU whose ready follows a programmable delay.
  always @(posedge clk) begin
    if (bus.vrf_req_o && bus.vrf_we_o)  envMem[bus.vrf_addr_o] <= bus.vrf_wdata_o;
    if (bus.vrf_req_o && !bus.vrf_we_o) bus.vrf_rdata_i <= envMem[bus.vrf_addr_o];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) validCnt <= 0;
    else if (bus.valu_valid_o && bus.valu_ready_i) validCnt <= 0;
    else if (bus.valu_valid_o) validCnt <= validCnt + 1;
  end

  assign bus.valu_ready_i  = bus.valu_valid_o && (validCnt >= readyDelay);
  assign bus.valu_result_i = aluFn(bus.op_a_o, bus.op_b_o, bus.op_c_o, curNsrc);

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.vrf_req_o) begin
        reqLog.push_back(int'(bus.vrf_addr_o));
        if (accQ.size() == 0) begin
          checkOutput("unexpectedReq", bus.vrf_req_o, 0);
        end else begin
          curAcc = accQ.pop_front();
          checkOutput("vrfWe", bus.vrf_we_o, curAcc.we);
          checkOutput("vrfAddr", bus.vrf_addr_o, curAcc.addr);
          if (curAcc.we) checkOutput("vrfWdata", bus.vrf_wdata_o, curAcc.data);
          checkOutput("doneOnAccess", doneO, curAcc.we && curAcc.last);
        end
      end else begin
        checkOutput("doneWithoutWrite", doneO, 0);
      end
      if (doneO) doneSeen++;
      if (bus.valu_valid_o) begin
        validCycles++;
        if (opQ.size() == 0) begin
          checkOutput("unexpectedValid", bus.valu_valid_o, 0);
        end else begin
          curOps = opQ[0];
          checkOutput("opA", bus.op_a_o, curOps.a);
          checkOutput("opB", bus.op_b_o, curOps.b);
          checkOutput("opC", bus.op_c_o, curOps.c);
          if (bus.valu_ready_i) kept = opQ.pop_front();
        end
      end
    end
  end

  task automatic modelIssue(input logic [4:0] vs2, input logic [4:0] vs1, input logic [4:0] vd,
                            input int nsrc, input int g);
    ops_t t;
    acc_t e;
    logic [4:0] a;
    t = kept;
    for (int i = 0; i < g; i++) begin
      if (nsrc >= 1) begin
        a = 5'(int'(vs2) + i); t.a = refMem[a];
        e.we = 1'b0; e.addr = a; e.data = '0; e.last = 1'b0; accQ.push_back(e);
      end
      if (nsrc >= 2) begin
        a = 5'(int'(vs1) + i); t.b = refMem[a];
        e.we = 1'b0; e.addr = a; e.data = '0; e.last = 1'b0; accQ.push_back(e);
      end
      if (nsrc == 3) begin
        a = 5'(int'(vd) + i); t.c = refMem[a];
        e.we = 1'b0; e.addr = a; e.data = '0; e.last = 1'b0; accQ.push_back(e);
      end
      opQ.push_back(t);
      e.we = 1'b1; e.addr = 5'(int'(vd) + i);
      e.data = aluFn(t.a, t.b, t.c, 2'(nsrc)); e.last = (i == g - 1);
      refMem[e.addr] = e.data;
      accQ.push_back(e);
    end
  endtask

  // Called at posedge+1 with the sequencer idle; the offer is taken at the next edge.
  task automatic applyStimulus(input logic [4:0] vs2, input logic [4:0] vs1, input logic [4:0] vd,
                               input int nsrc, input logic [2:0] lm, input logic [2:0] sew,
                               input int rdyDly, input logic killIdle, output logic legal);
    int g;
    g = modelG(lm);
    legal = (sew <= 3'd2) && (g != 0) && (int'(vd) % g == 0)
         && (nsrc < 1 || int'(vs2) % g == 0) && (nsrc < 2 || int'(vs1) % g == 0);
    readyDelay = rdyDly;
    curNsrc    = 2'(nsrc);
    if (legal) modelIssue(vs2, vs1, vd, nsrc, g);
    bus.start_valid_i = 1'b1;
    bus.vs2_i   = vs2;
    bus.vs1_i   = vs1;
    bus.vd_i    = vd;
    bus.nsrc_i  = 2'(nsrc);
    bus.vlmul_i = vlmul_e'(lm);
    bus.vsew_i  = vsew_e'(sew);
    kill        = killIdle;
    @(posedge clk); #1;
    bus.start_valid_i = 1'b0;
    kill = 1'b0;
  endtask

  task automatic finishInstr(input logic legal);
    int cyc;
    cyc = 0;
    if (!legal) begin
      @(negedge clk);
      checkOutput("illegalPulse", illegalO, 1);
      checkOutput("readyOnIllegal", bus.start_ready_o, 1);
      @(negedge clk);
      checkOutput("illegalOnce", illegalO, 0);
      @(posedge clk); #1;
    end else begin
      while (!doneO && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("doneInTime", (cyc < 300), 1);
      @(posedge clk); #1;
      checkOutput("readyAfterDone", bus.start_ready_o, 1);
      checkOutput("queuesDrained", accQ.size() + opQ.size(), 0);
      if (cyc >= 300) begin
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        accQ.delete(); opQ.delete();
        kept = '{a: '0, b: '0, c: '0};
        refMem = envMem;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       legal;
    logic [2:0] lm;
    logic [2:0] sew;
    logic [4:0] vs2, vs1, vd;
    int         g, cyc, doneBefore;
    int         exp2[12] = '{8, 16, 24, 9, 17, 25, 10, 18, 26, 11, 19, 27};
    vec_t       saved[32];

    for (int r = 0; r < 32; r++) begin
      envMem[r] = {4{24'hC0FFEE, 8'(r)}};
      refMem[r] = envMem[r];
    end
    kept = '{a: '0, b: '0, c: '0};
    bus.start_valid_i = 1'b0;
    bus.vs1_i = 5'd0; bus.vs2_i = 5'd0; bus.vd_i = 5'd0; bus.nsrc_i = 2'd0;
    bus.vlmul_i = VLMUL_1; bus.vsew_i = VSEW_8;

    // Reset values, and an offer during reset is ignored.
    #12;
    checkOutput("rstReady", bus.start_ready_o, 1);
    checkOutput("rstState", stateO, VRF_IDLE);
    checkOutput("rstReq", bus.vrf_req_o, 0);
    checkOutput("rstValid", bus.valu_valid_o, 0);
    checkOutput("rstOpA", bus.op_a_o, 0);
    checkOutput("rstWdata", bus.vrf_wdata_o, 0);
    bus.start_valid_i = 1'b1; bus.nsrc_i = 2'd1;
    @(posedge clk); #1;
    checkOutput("rstIgnoresStart", stateO, VRF_IDLE);
    bus.start_valid_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // vadd, cycle-exact with hand-computed data.
    applyStimulus(5'd4, 5'd8, 5'd12, 2, 3'd0, 3'd2, 0, 1'b0, legal);
    @(negedge clk);
    checkOutput("t1Rd1Req", bus.vrf_req_o, 1);
    checkOutput("t1Rd1Addr", bus.vrf_addr_o, 4);
    @(negedge clk);
    checkOutput("t1Rd2Addr", bus.vrf_addr_o, 8);
    @(negedge clk);
    checkOutput("t1NoValidYet", bus.valu_valid_o, 0);
    @(negedge clk);
    checkOutput("t1Valid", bus.valu_valid_o, 1);
    checkOutput("t1OpA", bus.op_a_o, {4{32'hC0FFEE04}});
    checkOutput("t1OpB", bus.op_b_o, {4{32'hC0FFEE08}});
    @(negedge clk);
    checkOutput("t1WrWe", bus.vrf_we_o, 1);
    checkOutput("t1WrAddr", bus.vrf_addr_o, 12);
    checkOutput("t1Done", doneO, 1);
    checkOutput("t1Wdata", bus.vrf_wdata_o, {32'h81FFDC0D, 32'h81FFDC0D, 32'h81FFDC0D, 32'h81FFDC0C});
    @(negedge clk);
    checkOutput("t1ReadyAgain", bus.start_ready_o, 1);
    @(posedge clk); #1;

    // LMUL=4 group walk.
    reqLog.delete();
    doneBefore = doneSeen;
    applyStimulus(5'd8, 5'd16, 5'd24, 2, 3'd2, 3'd1, 1, 1'b0, legal);
    finishInstr(legal);
    repeat (2) @(posedge clk); #1;
    checkOutput("t2Accesses", reqLog.size(), 12);
    if (reqLog.size() == 12)
      for (int i = 0; i < 12; i++) checkOutput("t2AddrSeq", reqLog[i], exp2[i]);
    checkOutput("t2DoneCount", doneSeen - doneBefore, 1);

    // vmv with a slow ALU.
    reqLog.delete();
    validCycles = 0;
    applyStimulus(5'd0, 5'd0, 5'd3, 0, 3'd0, 3'd0, 3, 1'b0, legal);
    finishInstr(legal);
    checkOutput("t3ValidCycles", validCycles, 4);
    checkOutput("t3Accesses", reqLog.size(), 1);
    if (reqLog.size() == 1) checkOutput("t3WrAddr", reqLog[0], 3);

    // Illegal SEW and misaligned destination.
    reqLog.delete();
    doneBefore = doneSeen;
    applyStimulus(5'd0, 5'd0, 5'd0, 1, 3'd0, 3'd7, 0, 1'b0, legal);
    finishInstr(legal);
    applyStimulus(5'd2, 5'd4, 5'd5, 2, 3'd1, 3'd0, 0, 1'b0, legal);
    finishInstr(legal);
    checkOutput("t4NoAccess", reqLog.size(), 0);
    checkOutput("t4NoDone", doneSeen - doneBefore, 0);

    // Kill during the first write of a three-source LMUL=2 instruction.
    saved = refMem;
    applyStimulus(5'd2, 5'd4, 5'd6, 3, 3'd1, 3'd2, 0, 1'b0, legal);
    cyc = 0;
    while (stateO != VRF_WRITE && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("t5ReachedWrite", (cyc < 50), 1);
    kill = 1'b1;
    @(negedge clk);
    checkOutput("t5NoWrite", bus.vrf_req_o, 0);
    checkOutput("t5NoDone", doneO, 0);
    @(posedge clk); #1;
    kill = 1'b0;
    checkOutput("t5Idle", stateO, VRF_IDLE);
    checkOutput("t5Remaining", accQ.size(), 5);
    checkOutput("t5OpsLeft", opQ.size(), 1);
    accQ.delete(); opQ.delete();
    refMem = saved;
    applyStimulus(5'd2, 5'd4, 5'd6, 3, 3'd1, 3'd2, 2, 1'b0, legal);
    finishInstr(legal);

    // Asynchronous reset while the ALU request is outstanding.
    saved = refMem;
    applyStimulus(5'd10, 5'd20, 5'd30, 2, 3'd1, 3'd0, 8, 1'b0, legal);
    cyc = 0;
    while (!(stateO == V_OP && bus.valu_valid_o) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("t6ReachedOp", (cyc < 50), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6State", stateO, VRF_IDLE);
    checkOutput("t6Ready", bus.start_ready_o, 1);
    checkOutput("t6Req", bus.vrf_req_o, 0);
    checkOutput("t6We", bus.vrf_we_o, 0);
    checkOutput("t6Valid", bus.valu_valid_o, 0);
    checkOutput("t6Done", doneO, 0);
    checkOutput("t6OpA", bus.op_a_o, 0);
    checkOutput("t6OpB", bus.op_b_o, 0);
    accQ.delete(); opQ.delete();
    kept = '{a: '0, b: '0, c: '0};
    refMem = saved;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    reqLog.delete();
    applyStimulus(5'd10, 5'd20, 5'd30, 2, 3'd1, 3'd0, 1, 1'b0, legal);
    finishInstr(legal);
    checkOutput("t6Accesses", reqLog.size(), 6);
    if (reqLog.size() == 6) begin
      checkOutput("t6FirstRead", reqLog[0], 10);
      checkOutput("t6FirstWrite", reqLog[2], 30);
    end

    // Randomized instructions, some illegal, some with kill in the idle accept cycle.
    for (int k = 0; k < 40; k++) begin
      lm  = 3'($urandom_range(0, 7));
      sew = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      g   = (modelG(lm) == 0) ? 1 : modelG(lm);
      vs2 = 5'($urandom_range(0, 31));
      vs1 = 5'($urandom_range(0, 31));
      vd  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) != 0) vs2 = vs2 & ~5'(g - 1);
      if ($urandom_range(0, 4) != 0) vs1 = vs1 & ~5'(g - 1);
      if ($urandom_range(0, 4) != 0) vd  = vd  & ~5'(g - 1);
      applyStimulus(vs2, vs1, vd, int'($urandom_range(0, 3)), lm, sew,
                    int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), legal);
      finishInstr(legal);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
